led_serial_rx: RTL and testbench

- Receive end of the LED serial link driven by led_ctrl_top.
- Oversamples the link clock cko_i and the parallel data lanes sdo_i on a single system clock, deserialises 12-bit {R,G,B} words per lane, and reports frame boundaries and framing errors.
- Used as the loopback capture and checker in front of the LED driver model, and as the capture block in board bring-up.

---
 rtl/led_link_pkg.sv | 24 ++
 rtl/led_serial_rx_if.sv | 37 +++
 rtl/led_lane_sync.sv | 25 ++
 rtl/led_serial_rx.sv | 183 ++++++++++++++++++
 tb/tb_led_serial_rx.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_link_pkg.sv
// LED serial link shared definitions.
// Word layout, default geometry and rx state encoding.
package led_link_pkg;

  localparam int WORD_W = 12;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  localparam int LANES_DEF = 8;
  localparam int WPF_DEF   = 8;
  localparam int GAP_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVR  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/led_serial_rx_if.sv
// LED serial receiver output bundle.
// master drives words and frame events, slave consumes.
interface led_serial_rx_if #(
  parameter int LANES           = 8,
  parameter int WORD_W          = 12,
  parameter int WORDS_PER_FRAME = 8
);

  localparam int IW =
    (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  logic                    word_valid;
  logic [LANES*WORD_W-1:0] word_data;
  logic [IW-1:0]           word_idx;
  logic                    frame_done;
  logic                    frame_err;
  logic                    busy;

  modport master (
    output word_valid,
    output word_data,
    output word_idx,
    output frame_done,
    output frame_err,
    output busy
  );

  modport slave (
    input word_valid,
    input word_data,
    input word_idx,
    input frame_done,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/led_lane_sync.sv
// Two-flop synchroniser for the link clock and data lanes.
// One instance keeps cko and sdo on identical delay.
module led_lane_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] s1;

  // metastability chain, cleared by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/led_serial_rx.sv
// LED serial link receiver.
// Oversamples cko/sdo, deserialises words, checks framing.
module led_serial_rx #(
  parameter int LANES           = led_link_pkg::LANES_DEF,
  parameter int WORD_W          = led_link_pkg::WORD_W,
  parameter int WORDS_PER_FRAME = led_link_pkg::WPF_DEF,
  parameter int GAP_CYC         = led_link_pkg::GAP_DEF
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic             en,
  input  logic             cko_i,
  input  logic [LANES-1:0] sdo_i,
  led_serial_rx_if.master  rx
);

  import led_link_pkg::*;

  localparam int BW = $clog2(WORD_W);
  localparam int CW =
    (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WORDS_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYC);
  localparam logic [GW-1:0] GAP_EXP   = GW'(GAP_CYC - 1);

  logic [LANES:0]   sync_q;
  logic             cko_s2;
  logic [LANES-1:0] sdo_s2;
  logic             cko_d;
  logic             rise;
  logic             qrise;

  rx_state_t state, state_n;

  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [CW-1:0] word_cnt, word_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          pend, pend_n;

  logic [LANES-1:0][WORD_W-1:0] shreg;
  logic [LANES-1:0][WORD_W-1:0] shreg_nx;

  logic shift_en;
  logic word_ld;
  logic fd_n;
  logic fe_n;

  logic                    wv_q;
  logic [LANES*WORD_W-1:0] wd_q;
  logic [CW-1:0]           wi_q;
  logic                    fd_q;
  logic                    fe_q;

  led_lane_sync #(
    .N (LANES + 1)
  ) u_sync (
    .clk  (clk_fast),
    .rstn (rstn),
    .d    ({cko_i, sdo_i}),
    .q    (sync_q)
  );

  assign cko_s2 = sync_q[LANES];
  assign sdo_s2 = sync_q[LANES-1:0];
  assign rise   = cko_s2 & ~cko_d;
  assign qrise  = rise & en;

  // delayed synchronised cko for rise detection
  always_ff @(posedge clk_fast) begin
    if (!rstn) cko_d <= 1'b0;
    else       cko_d <= cko_s2;
  end

  // every lane shifts at the LSB; first bit ends up as MSB
  always_comb begin
    shreg_nx = shreg;
    for (int k = 0; k < LANES; k++) begin
      shreg_nx[k] = {shreg[k][WORD_W-2:0], sdo_s2[k]};
    end
  end

  // idle time since the last accepted rise, saturating
  always_comb begin
    gap_cnt_n = gap_cnt;
    if (qrise)                  gap_cnt_n = '0;
    else if (gap_cnt != GAP_MAX) gap_cnt_n = gap_cnt + GW'(1);
  end

  // framing state machine, counters and event pulses
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    pend_n     = pend;
    shift_en   = 1'b0;
    word_ld    = 1'b0;
    fd_n       = 1'b0;
    fe_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (qrise) begin
          if (gap_cnt == GAP_MAX) begin
            state_n   = RECV;
            shift_en  = 1'b1;
            bit_cnt_n = BW'(1);
          end else begin
            state_n = OVR;
            fe_n    = 1'b1;
          end
        end
      end
      RECV: begin
        if (pend) begin
          pend_n    = 1'b0;
          word_ld   = 1'b1;
          bit_cnt_n = '0;
          if (word_cnt == WORD_LAST) begin
            fd_n       = 1'b1;
            word_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            word_cnt_n = word_cnt + CW'(1);
          end
        end else if (qrise) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) pend_n = 1'b1;
          else bit_cnt_n = bit_cnt + BW'(1);
        end else if (gap_cnt == GAP_EXP) begin
          fe_n       = 1'b1;
          bit_cnt_n  = '0;
          word_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      OVR: begin
        if (gap_cnt == GAP_MAX) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_fast) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      gap_cnt  <= GAP_MAX;
      pend     <= 1'b0;
      shreg    <= '0;
      wv_q     <= 1'b0;
      wd_q     <= '0;
      wi_q     <= '0;
      fd_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      word_cnt <= word_cnt_n;
      gap_cnt  <= gap_cnt_n;
      pend     <= pend_n;
      if (shift_en) shreg <= shreg_nx;
      wv_q <= word_ld;
      if (word_ld) begin
        wd_q <= shreg;
        wi_q <= word_cnt;
      end
      fd_q <= fd_n;
      fe_q <= fe_n;
    end
  end

  assign rx.word_valid = wv_q;
  assign rx.word_data  = wd_q;
  assign rx.word_idx   = wi_q;
  assign rx.frame_done = fd_q;
  assign rx.frame_err  = fe_q;
  assign rx.busy       = (state == RECV);

endmodule

// File: tb/tb_led_serial_rx.sv
// Directed bench for led_serial_rx.
// Drives a model transmitter and checks words and frame events.
module tb_led_serial_rx;

  localparam int LANES = 8;
  localparam int WW    = 12;
  localparam int WPF   = 8;
  localparam int GAP   = 16;
  localparam int DW    = LANES * WW;

  logic             clk_fast = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b1;
  logic             cko_i = 1'b0;
  logic [LANES-1:0] sdo_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int last_rise = 0;

  int wv_cnt = 0;
  int fd_cnt = 0;
  int fe_cnt = 0;
  int fe_cyc = 0;

  logic [DW-1:0] wd_q[$];
  int            idx_q[$];
  logic          fdw_q[$];
  int            wcyc_q[$];

  led_serial_rx_if #(
    .LANES           (LANES),
    .WORD_W          (WW),
    .WORDS_PER_FRAME (WPF)
  ) rx ();

  led_serial_rx #(
    .LANES           (LANES),
    .WORD_W          (WW),
    .WORDS_PER_FRAME (WPF),
    .GAP_CYC         (GAP)
  ) dut (
    .clk_fast (clk_fast),
    .rstn     (rstn),
    .en       (en),
    .cko_i    (cko_i),
    .sdo_i    (sdo_i),
    .rx       (rx)
  );

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) cyc <= cyc + 1;

  always @(negedge clk_fast) begin
    if (rx.word_valid === 1'b1) begin
      wv_cnt <= wv_cnt + 1;
      wd_q.push_back(rx.word_data);
      idx_q.push_back(int'(rx.word_idx));
      fdw_q.push_back(rx.frame_done);
      wcyc_q.push_back(cyc);
    end
    if (rx.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (rx.frame_err === 1'b1) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  function automatic logic [WW-1:0] exp_word(
    input int pat, input int k, input int i);
    if (pat == 0) return {4'(i + 1), 4'(i + 1), 4'(i + 1)};
    return {4'(i + 1), 4'(k), 4'(i + k + 3)};
  endfunction

  function automatic logic [DW-1:0] exp_vec(
    input int pat, input int i);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++)
      v[k*WW +: WW] = exp_word(pat, k, i);
    return v;
  endfunction

  task automatic send_bit(input logic [LANES-1:0] b);
    cko_i = 1'b0;
    sdo_i = b;
    repeat (4) @(negedge clk_fast);
    cko_i = 1'b1;
    last_rise = cyc;
    repeat (4) @(negedge clk_fast);
  endtask

  task automatic send_word(
    input int pat, input int i, input int nbits);
    logic [LANES-1:0] bits;
    logic [WW-1:0]    w;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < LANES; k++) begin
        w = exp_word(pat, k, i);
        bits[k] = w[WW-1-b];
      end
      send_bit(bits);
    end
  endtask

  task automatic idle(input int n);
    cko_i = 1'b0;
    sdo_i = '0;
    repeat (n) @(negedge clk_fast);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    en = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(50);
    n_checks++;
    if (rx.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wv got %b want 0", rx.word_valid);
    end
    n_checks++;
    if (rx.frame_done !== 1'b0 || rx.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pulses got %b%b want 00",
        rx.frame_done, rx.frame_err);
    end
    n_checks++;
    if (rx.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b want 0", rx.busy);
    end
    n_checks++;
    if (rx.word_data !== '0 || rx.word_idx !== '0) begin
      n_fail++;
      $display("FAIL rst_data got %h/%0d want 0/0",
        rx.word_data, rx.word_idx);
    end
    n_checks++;
    if (wv_cnt + fd_cnt + fe_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_events got %0d want 0",
        wv_cnt + fd_cnt + fe_cnt);
    end
  endtask

  task automatic test_full_frame;
    int wb, fdb, feb, r0;
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    send_word(0, 0, WW);
    r0 = last_rise;
    n_checks++;
    if (rx.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ff_busy got %b want 1", rx.busy);
    end
    for (int i = 1; i < WPF; i++) send_word(0, i, WW);
    idle(30);
    n_checks++;
    if (wv_cnt - wb !== WPF) begin
      n_fail++;
      $display("FAIL ff_wv got %0d want %0d", wv_cnt - wb, WPF);
    end
    n_checks++;
    if (fd_cnt - fdb !== 1 || fe_cnt - feb !== 0) begin
      n_fail++;
      $display("FAIL ff_events got fd=%0d fe=%0d want 1/0",
        fd_cnt - fdb, fe_cnt - feb);
    end
    if (wd_q.size() >= wb + WPF) begin
      n_checks++;
      if (wd_q[wb][WW-1:0] !== 12'h111) begin
        n_fail++;
        $display("FAIL ff_w0 got %h want 111", wd_q[wb][WW-1:0]);
      end
      n_checks++;
      if (wcyc_q[wb] - r0 !== 4) begin
        n_fail++;
        $display("FAIL ff_lat got %0d want 4", wcyc_q[wb] - r0);
      end
      for (int i = 0; i < WPF; i++) begin
        n_checks++;
        if (wd_q[wb+i] !== exp_vec(0, i) || idx_q[wb+i] !== i ||
            fdw_q[wb+i] !== (i == WPF - 1)) begin
          n_fail++;
          $display("FAIL ff_word%0d got %h/%0d/%b want %h/%0d/%b",
            i, wd_q[wb+i], idx_q[wb+i], fdw_q[wb+i],
            exp_vec(0, i), i, (i == WPF - 1));
        end
      end
    end
    n_checks++;
    if (rx.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_busy_end got %b want 0", rx.busy);
    end
  endtask

  task automatic test_gap_err;
    int wb, fdb, feb;
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    send_word(1, 0, WW);
    send_word(1, 1, WW);
    send_word(1, 2, 5);
    idle(40);
    n_checks++;
    if (wv_cnt - wb !== 2 || fd_cnt - fdb !== 0) begin
      n_fail++;
      $display("FAIL gap_wv got wv=%0d fd=%0d want 2/0",
        wv_cnt - wb, fd_cnt - fdb);
    end
    n_checks++;
    if (fe_cnt - feb !== 1) begin
      n_fail++;
      $display("FAIL gap_fe got %0d want 1", fe_cnt - feb);
    end
    n_checks++;
    if (fe_cyc - last_rise !== GAP + 3) begin
      n_fail++;
      $display("FAIL gap_time got %0d want %0d",
        fe_cyc - last_rise, GAP + 3);
    end
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    for (int i = 0; i < WPF; i++) send_word(1, i, WW);
    idle(30);
    n_checks++;
    if (wv_cnt - wb !== WPF || fd_cnt - fdb !== 1 ||
        fe_cnt - feb !== 0) begin
      n_fail++;
      $display("FAIL gap_next got %0d/%0d/%0d want 8/1/0",
        wv_cnt - wb, fd_cnt - fdb, fe_cnt - feb);
    end
    for (int i = 0; i < WPF && wb + i < wd_q.size(); i++) begin
      n_checks++;
      if (wd_q[wb+i] !== exp_vec(1, i) || idx_q[wb+i] !== i) begin
        n_fail++;
        $display("FAIL gap_word%0d got %h/%0d want %h/%0d",
          i, wd_q[wb+i], idx_q[wb+i], exp_vec(1, i), i);
      end
    end
  endtask

  task automatic test_overrun;
    int wb, fdb, feb;
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    for (int i = 0; i <= WPF; i++) send_word(0, i, WW);
    idle(40);
    n_checks++;
    if (wv_cnt - wb !== WPF) begin
      n_fail++;
      $display("FAIL ovr_wv got %0d want %0d", wv_cnt - wb, WPF);
    end
    n_checks++;
    if (fd_cnt - fdb !== 1 || fe_cnt - feb !== 1) begin
      n_fail++;
      $display("FAIL ovr_events got fd=%0d fe=%0d want 1/1",
        fd_cnt - fdb, fe_cnt - feb);
    end
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    for (int i = 0; i < WPF; i++) send_word(1, i, WW);
    idle(30);
    n_checks++;
    if (wv_cnt - wb !== WPF || fd_cnt - fdb !== 1 ||
        fe_cnt - feb !== 0) begin
      n_fail++;
      $display("FAIL ovr_next got %0d/%0d/%0d want 8/1/0",
        wv_cnt - wb, fd_cnt - fdb, fe_cnt - feb);
    end
    for (int i = 0; i < WPF && wb + i < wd_q.size(); i++) begin
      n_checks++;
      if (wd_q[wb+i] !== exp_vec(1, i) || idx_q[wb+i] !== i) begin
        n_fail++;
        $display("FAIL ovr_word%0d got %h/%0d want %h/%0d",
          i, wd_q[wb+i], idx_q[wb+i], exp_vec(1, i), i);
      end
    end
  endtask

  task automatic test_enable;
    int wb, fdb, feb;
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    en = 1'b0;
    for (int i = 0; i < WPF; i++) send_word(0, i, WW);
    idle(30);
    en = 1'b1;
    n_checks++;
    if (wv_cnt - wb !== 0 || fd_cnt - fdb !== 0 ||
        fe_cnt - feb !== 0) begin
      n_fail++;
      $display("FAIL en_off got %0d/%0d/%0d want 0/0/0",
        wv_cnt - wb, fd_cnt - fdb, fe_cnt - feb);
    end
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    for (int i = 0; i < 3; i++) send_word(1, i, WW);
    en = 1'b0;
    for (int i = 3; i < WPF; i++) send_word(1, i, WW);
    idle(30);
    en = 1'b1;
    n_checks++;
    if (wv_cnt - wb !== 3 || fd_cnt - fdb !== 0) begin
      n_fail++;
      $display("FAIL en_drop_wv got wv=%0d fd=%0d want 3/0",
        wv_cnt - wb, fd_cnt - fdb);
    end
    n_checks++;
    if (fe_cnt - feb !== 1) begin
      n_fail++;
      $display("FAIL en_drop_fe got %0d want 1", fe_cnt - feb);
    end
  endtask

  task automatic test_reset_mid;
    int wb, fdb, feb;
    for (int i = 0; i < 3; i++) send_word(1, i, WW);
    send_word(1, 3, 6);
    cko_i = 1'b0;
    rstn = 1'b0;
    @(negedge clk_fast);
    rstn = 1'b1;
    n_checks++;
    if (rx.word_data !== '0 || rx.word_idx !== '0) begin
      n_fail++;
      $display("FAIL rmid_data got %h/%0d want 0/0",
        rx.word_data, rx.word_idx);
    end
    n_checks++;
    if (rx.busy !== 1'b0 || rx.word_valid !== 1'b0 ||
        rx.frame_err !== 1'b0 || rx.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_ctl got b%b v%b e%b d%b want 0000",
        rx.busy, rx.word_valid, rx.frame_err, rx.frame_done);
    end
    idle(GAP + 4);
    wb = wv_cnt; fdb = fd_cnt; feb = fe_cnt;
    for (int i = 0; i < WPF; i++) send_word(0, i, WW);
    idle(30);
    n_checks++;
    if (wv_cnt - wb !== WPF || fd_cnt - fdb !== 1 ||
        fe_cnt - feb !== 0) begin
      n_fail++;
      $display("FAIL rmid_next got %0d/%0d/%0d want 8/1/0",
        wv_cnt - wb, fd_cnt - fdb, fe_cnt - feb);
    end
    for (int i = 0; i < WPF && wb + i < wd_q.size(); i++) begin
      n_checks++;
      if (wd_q[wb+i] !== exp_vec(0, i) || idx_q[wb+i] !== i) begin
        n_fail++;
        $display("FAIL rmid_word%0d got %h/%0d want %h/%0d",
          i, wd_q[wb+i], idx_q[wb+i], exp_vec(0, i), i);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_fast);
    test_reset;
    test_full_frame;
    test_gap_err;
    test_overrun;
    test_enable;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
